seq_det_ctrl: RTL and testbench

Controller for a programmable serial pattern detector. It holds the pattern configuration, sequences arm, fill and detect phases, and throttles the serial stream with a ready signal. It reports each match to a downstream consumer over a req/ack handshake and counts matches up to a programmable target. It sits between the serial source and a match consumer, such as an interrupt or DMA trigger.

---
 rtl/seq_det_ctrl_if.sv | 12 +
 rtl/seq_det_ctrl.sv | 134 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Serial bit stream and match-report handshake shared by the detector
// controller (slave) and its source/consumer side (master).
interface seq_det_ctrl_if;
    logic x_valid;
    logic x_in;
    logic x_ready;
    logic det_req;
    logic det_ack;

    modport master (output x_valid, x_in, det_ack, input x_ready, det_req);
    modport slave  (input x_valid, x_in, det_ack, output x_ready, det_req);
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector controller: arms, fills the shift
// window, detects matches and reports each one over a req/ack handshake.
module seq_det_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    localparam int LW     = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    seq_det_ctrl_if.slave      xif,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_ACK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] win_q, win_d, pat_q, pat_d;
    logic [LW-1:0]      fill_q, fill_d, len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, tgt_q, tgt_d;

    logic [LW-1:0]      len_eff, fill_inc;
    logic [MAX_LEN-1:0] mask, new_win;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept, hit;

    assign xif.x_ready = (state_q == S_FILL) || (state_q == S_RUN);
    assign xif.det_req = (state_q == S_ACK);
    assign busy        = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_ACK);
    assign done        = (state_q == S_DONE);
    assign match_cnt   = cnt_q;

    // A cleared length register still behaves as a 1-bit pattern.
    always_comb begin
        len_eff = (len_q == '0) ? LW'(1) : len_q;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_eff));
    end

    assign accept   = xif.x_valid && xif.x_ready;
    assign new_win  = {win_q[MAX_LEN-2:0], xif.x_in};
    assign hit      = ((new_win ^ pat_q) & mask) == '0;
    assign fill_inc = fill_q + LW'(1);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        len_d   = len_q;
        tgt_d   = tgt_q;
        if (abort) begin
            state_d = S_IDLE;
            win_d   = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_we) begin
                        pat_d = cfg_pattern;
                        tgt_d = cfg_target;
                        if (cfg_len == '0)                 len_d = LW'(1);
                        else if (cfg_len > LW'(MAX_LEN))   len_d = LW'(MAX_LEN);
                        else                               len_d = cfg_len;
                    end
                    if (start) begin
                        state_d = S_FILL;
                        win_d   = '0;
                        fill_d  = '0;
                        cnt_d   = '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        win_d  = new_win;
                        fill_d = fill_inc;
                        // The bit that completes the window is already a candidate.
                        if (fill_inc == len_eff) begin
                            if (hit) begin
                                state_d = S_ACK;
                                cnt_d   = cnt_inc;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        win_d = new_win;
                        if (hit) begin
                            state_d = S_ACK;
                            cnt_d   = cnt_inc;
                        end
                    end
                end
                S_ACK: begin
                    if (xif.det_ack)
                        state_d = (tgt_q != '0 && cnt_q == tgt_q) ? S_DONE : S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-history reference model predicts
// each match count; a monitor pops predictions whenever det_req rises.
module tb_seq_det_ctrl;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;
    localparam int LW      = $clog2(MAX_LEN) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 0;
    logic               reset_n = 0;
    logic               cfg_we = 0, start = 0, abort = 0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy, done;
    logic               auto_ack = 0, man_ack = 0;

    seq_det_ctrl_if xif();
    assign xif.det_ack = auto_ack | man_ack;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .abort(abort),
        .xif(xif.slave), .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // reference model: every accepted bit since start, plus config
    bit               hist[$];
    logic [MAX_LEN-1:0] m_pat = '0;
    int               m_len = 1, m_tgt = 0, m_cnt = 0;
    bit               m_done = 0;
    int               exp_q[$];

    bit ack_en = 0;
    int ack_lat_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    task automatic model_bit(input bit b);
        bit ok;
        hist.push_back(b);
        if (hist.size() >= m_len) begin
            ok = 1;
            for (int i = 0; i < m_len; i++)
                if (hist[hist.size() - 1 - i] != m_pat[i]) ok = 0;
            if (ok) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                exp_q.push_back(m_cnt);
                if (m_tgt != 0 && m_cnt == m_tgt) m_done = 1;
            end
        end
    endtask

    // monitor: one prediction per det_req rising edge
    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (xif.det_req && !prev) begin
                if (exp_q.size() == 0) fail_now("det_req_spurious");
                else check("match_cnt_at_req", match_cnt, exp_q.pop_front());
            end
            if (xif.det_req) check("x_ready_low_in_ack", xif.x_ready, 0);
            prev = xif.det_req;
        end
    end

    // consumer: acknowledges after a random 0..ack_lat_max cycle delay
    initial begin
        int wait_cnt, lat;
        wait_cnt = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            auto_ack = 0;
            if (ack_en && xif.det_req) begin
                if (wait_cnt >= lat) begin
                    auto_ack = 1;
                    wait_cnt = 0;
                    lat = $urandom_range(0, ack_lat_max);
                end else wait_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        int guard;
        guard = 0;
        xif.x_valid = 1;
        xif.x_in = b;
        while (!xif.x_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!xif.x_ready) fail_now("x_ready_timeout");
        else begin
            @(posedge clk);
            model_bit(b);
            @(negedge clk);
        end
        xif.x_valid = 0;
        xif.x_in = 1'($urandom);
    endtask

    task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int l, input int t, input bit honoured);
        cfg_pattern = p;
        cfg_len = LW'(l);
        cfg_target = CNT_W'(t);
        cfg_we = 1;
        tick(1);
        cfg_we = 0;
        if (honoured) begin
            m_pat = p;
            m_len = clamp_len(l);
            m_tgt = t;
        end
    endtask

    task automatic do_start();
        start = 1;
        tick(1);
        start = 0;
        hist.delete();
        m_cnt = 0;
        m_done = 0;
    endtask

    task automatic do_abort();
        abort = 1;
        tick(1);
        abort = 0;
        hist.delete();
        m_done = 0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (xif.det_req && guard < 40) begin
            tick(1);
            guard++;
        end
        if (xif.det_req) fail_now("ack_drain_timeout");
        tick(2);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [11:0] edb;
        xif.x_valid = 0;
        xif.x_in = 0;
        edb = 12'hEDB;

        tick(2);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x_ready", xif.x_ready, 0);
        check("rst_det_req", xif.det_req, 0);
        reset_n = 1;
        tick(1);

        // 12-bit pattern, target 2
        ack_en = 1;
        ack_lat_max = 0;
        do_cfg(16'h0EDB, 12, 2, 1);
        do_start();
        check("start_busy", busy, 1);
        check("start_x_ready", xif.x_ready, 1);
        for (int i = 11; i >= 0; i--) send_bit(edb[i]);
        check("edb_req1", xif.det_req, 1);
        check("edb_cnt1", match_cnt, 1);
        for (int i = 11; i >= 0; i--) send_bit(edb[i]);
        check("edb_cnt2", match_cnt, 2);
        wait_idle();
        check("edb_done", done, 1);
        check("edb_busy", busy, 0);
        check("edb_x_ready", xif.x_ready, 0);

        // overlapping 101, unlimited target
        do_cfg(16'h0005, 3, 0, 1);
        do_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        wait_idle();
        check("ovl_cnt", match_cnt, 2);
        check("ovl_done", done, 0);
        check("ovl_busy", busy, 1);

        // ack withheld: stream must stall and window must not move
        ack_en = 0;
        tick(1);
        send_bit(0); send_bit(1);
        xif.x_valid = 1;
        xif.x_in = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_x_ready", xif.x_ready, 0);
            check("hold_det_req", xif.det_req, 1);
            check("hold_cnt", match_cnt, m_cnt);
        end
        xif.x_valid = 0;
        man_ack = 1;
        tick(1);
        man_ack = 0;
        check("hold_release_req", xif.det_req, 0);
        check("hold_release_ready", xif.x_ready, 1);
        ack_en = 1;
        ack_lat_max = 2;
        send_bit(0); send_bit(1);
        wait_idle();
        check("hold_cnt_after", match_cnt, m_cnt);

        // config write while running is ignored
        do_cfg(16'h0006, 3, 0, 0);
        for (int i = 0; i < 24; i++) send_bit(1'($urandom));
        wait_idle();
        check("run_cfg_cnt", match_cnt, m_cnt);

        // length 0 clamps to a single bit
        do_abort();
        do_cfg(16'hAAA5, 0, 0, 1);
        do_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        wait_idle();
        check("len0_cnt", match_cnt, 3);

        // abort + start + ack together in ACK
        ack_en = 0;
        tick(1);
        send_bit(1);
        check("pre_abort_req", xif.det_req, 1);
        abort = 1;
        start = 1;
        man_ack = 1;
        tick(1);
        abort = 0;
        start = 0;
        man_ack = 0;
        hist.delete();
        check("abort_req", xif.det_req, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt_kept", match_cnt, m_cnt);
        do_start();
        check("restart_cnt", match_cnt, 0);
        check("restart_busy", busy, 1);
        ack_en = 1;

        // counter saturation
        ack_lat_max = 0;
        do_abort();
        do_cfg(16'h0001, 1, 0, 1);
        do_start();
        for (int i = 0; i < CNT_MAX + 3; i++) send_bit(1);
        wait_idle();
        check("sat_cnt", match_cnt, CNT_MAX);

        // randomized rounds
        ack_lat_max = 3;
        for (int r = 0; r < 25; r++) begin
            do_abort();
            do_cfg(MAX_LEN'($urandom), $urandom_range(0, 20), $urandom_range(0, 3), 1);
            do_start();
            for (int n = 0; n < 80 && !m_done; n++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = m_len - 1; i >= 0 && !m_done; i--) send_bit(m_pat[i]);
                end else send_bit(1'($urandom));
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            wait_idle();
            check("rand_cnt", match_cnt, m_cnt);
            check("rand_done", done, m_done);
        end

        // reset mid-RUN with det_req pending
        ack_en = 0;
        do_abort();
        do_cfg(16'h0005, 3, 0, 1);
        do_start();
        send_bit(1); send_bit(0); send_bit(1);
        check("pre_rst_req", xif.det_req, 1);
        #2 reset_n = 0;
        #1;
        check("async_rst_req", xif.det_req, 0);
        check("async_rst_cnt", match_cnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_x_ready", xif.x_ready, 0);
        check("async_rst_done", done, 0);
        exp_q.delete();
        hist.delete();
        m_pat = '0;
        m_len = 1;
        m_tgt = 0;
        m_cnt = 0;
        m_done = 0;
        tick(1);
        reset_n = 1;
        tick(1);
        check("post_rst_busy", busy, 0);
        check("post_rst_x_ready", xif.x_ready, 0);
        ack_en = 1;
        do_start();
        send_bit(0); send_bit(1);
        wait_idle();
        check("post_rst_cfg_cleared", match_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
